// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared constants for the ARM-style pipeline: default data path
//            width, register index width and the index of the PC register.
// Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // Default data path width of the pipeline.
  localparam int DATA_W       = 32;

  // Default width of a register-file index (r0..r15).
  localparam int REG_ADDR_W   = 4;

  // Register index that aliases the program counter; writes to it are
  // routed to the fetch logic instead of the register file.
  localparam int PC_IDX       = 15;

  // Width of the optional retired-instruction counter.
  localparam int RETIRE_CNT_W = 32;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_mux
// Brief    : Writeback result selector. Chooses the load data or the ALU
//            result from already-registered pipeline state, so its output
//            is stable for the whole cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              sel_mem,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [DATA_W-1:0] mem_val,
  output logic [DATA_W-1:0] result
);

  // Load instructions write back memory data, everything else the ALU value.
  always_comb begin
    result = alu_val;
    if (sel_mem) begin
      result = mem_val;
    end
  end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage. Holds the MEM/WB pipeline register, selects the
//            writeback result and qualifies the register-file / PC write
//            enables. Supports freeze (hold) and flush (insert bubble).
//            Optional feature macro: WB_RETIRE_CNT_EN adds a 32-bit
//            retired-instruction counter on output retire_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int DATA_W     = arm_pkg::DATA_W,
  parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  input  logic [DATA_W-1:0]     ALU_Res,
  input  logic [DATA_W-1:0]     Mem_read_value,
  output logic [DATA_W-1:0]     Result_WB,
  output logic [REG_ADDR_W-1:0] Dest_wb,
  output logic                  writeBackEn,
  output logic                  wb_pc_write,
  output logic                  wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [arm_pkg::RETIRE_CNT_W-1:0] retire_cnt
`endif
);

  import arm_pkg::*;

  // PC index expressed at the configured register index width.
  localparam logic [REG_ADDR_W-1:0] c_pc_dest = REG_ADDR_W'(PC_IDX);

  // --------------------------------------------------------------------------
  // Pipeline register state
  // --------------------------------------------------------------------------
  logic                  valid_q,  valid_d;
  logic                  wb_en_q,  wb_en_d;
  logic                  mem_r_q,  mem_r_d;
  logic [REG_ADDR_W-1:0] dest_q,   dest_d;
  logic [DATA_W-1:0]     alu_q,    alu_d;
  logic [DATA_W-1:0]     mem_q,    mem_d;

  // Qualification wires
  logic                  w_wb_req;
  logic                  w_is_pc;

  // Next-state of the pipeline register: flush wins over freeze, freeze
  // holds, otherwise capture the MEM-stage outputs.
  always_comb begin
    valid_d = valid_q;
    wb_en_d = wb_en_q;
    mem_r_d = mem_r_q;
    dest_d  = dest_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    if (flush) begin
      // Bubble: only the qualifiers are cleared; the payload is don't-care.
      valid_d = 1'b0;
      wb_en_d = 1'b0;
    end else if (!freeze) begin
      valid_d = mem_valid;
      wb_en_d = WB_EN_in;
      mem_r_d = MEM_R_EN;
      dest_d  = Dest_in;
      alu_d   = ALU_Res;
      mem_d   = Mem_read_value;
    end
  end

  // MEM/WB pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      dest_q  <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wb_en_q <= wb_en_d;
      mem_r_q <= mem_r_d;
      dest_q  <= dest_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result selection (registered inputs only, so the value settles right
  // after the clock edge and stays put for a negedge-write register file)
  // --------------------------------------------------------------------------
  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .sel_mem (mem_r_q),
    .alu_val (alu_q),
    .mem_val (mem_q),
    .result  (Result_WB)
  );

  // Write-enable qualification: a real instruction that requests writeback
  // goes either to the register file (r0..r14) or to the PC, never both.
  always_comb begin
    w_wb_req    = valid_q & wb_en_q;
    w_is_pc     = (dest_q == c_pc_dest);
    writeBackEn = w_wb_req & ~w_is_pc;
    wb_pc_write = w_wb_req &  w_is_pc;
    Dest_wb     = dest_q;
    wb_valid    = valid_q;
  end

`ifdef WB_RETIRE_CNT_EN
  // --------------------------------------------------------------------------
  // Retired-instruction counter: an entry retires when it is valid and the
  // stage is allowed to advance. Wraps naturally at 2^32.
  // --------------------------------------------------------------------------
  logic [RETIRE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // Count one retirement per advancing cycle with a valid entry.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (valid_q && !freeze) begin
      retire_cnt_d = retire_cnt_q + RETIRE_CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage. Random and directed stimulus
//            compared against a behavioural model of the writeback stage.
//            Counter checks are compiled in with WB_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze, flush, mem_valid, WB_EN_in, MEM_R_EN;
  logic [AW-1:0] Dest_in;
  logic [DW-1:0] ALU_Res, Mem_read_value;
  logic [DW-1:0] Result_WB;
  logic [AW-1:0] Dest_wb;
  logic          writeBackEn, wb_pc_write, wb_valid;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]   retire_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model: the instruction currently sitting in writeback.
  typedef struct {
    bit        valid;
    bit        wb_en;
    bit        is_load;
    int        dest;
    bit [31:0] alu;
    bit [31:0] mem;
  } entry_t;

  entry_t    m_ent;
  bit [31:0] m_cnt;

  wb_stage #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .WB_EN_in       (WB_EN_in),
    .MEM_R_EN       (MEM_R_EN),
    .Dest_in        (Dest_in),
    .ALU_Res        (ALU_Res),
    .Mem_read_value (Mem_read_value),
    .Result_WB      (Result_WB),
    .Dest_wb        (Dest_wb),
    .writeBackEn    (writeBackEn),
    .wb_pc_write    (wb_pc_write),
    .wb_valid       (wb_valid)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt     (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ent = '{valid: 0, wb_en: 0, is_load: 0, dest: 0, alu: 0, mem: 0};
    m_cnt = 0;
  endtask

  // Expected outputs come straight from the meaning of the held instruction.
  task automatic check_all(input string ph);
    bit [31:0] e_res;
    bit        writes;
    e_res  = m_ent.is_load ? m_ent.mem : m_ent.alu;
    writes = m_ent.valid && m_ent.wb_en;
    check({ph, ".Result_WB"},   64'(Result_WB),   64'(e_res));
    check({ph, ".Dest_wb"},     64'(Dest_wb),     64'(m_ent.dest));
    check({ph, ".writeBackEn"}, 64'(writeBackEn), 64'(writes && m_ent.dest != 15));
    check({ph, ".wb_pc_write"}, 64'(wb_pc_write), 64'(writes && m_ent.dest == 15));
    check({ph, ".wb_valid"},    64'(wb_valid),    64'(m_ent.valid));
`ifdef WB_RETIRE_CNT_EN
    check({ph, ".retire_cnt"},  64'(retire_cnt),  64'(m_cnt));
`endif
  endtask

  task automatic drive(input bit v, input bit we, input bit ld, input int d,
                       input bit [31:0] alu, input bit [31:0] mem,
                       input bit fz, input bit fl);
    mem_valid      = v;
    WB_EN_in       = we;
    MEM_R_EN       = ld;
    Dest_in        = AW'(d);
    ALU_Res        = alu;
    Mem_read_value = mem;
    freeze         = fz;
    flush          = fl;
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then compare just after the edge.
  task automatic tick(input string ph);
    @(posedge clk);
    if (m_ent.valid && !freeze) m_cnt++;
    if (flush) begin
      m_ent.valid = 0;
      m_ent.wb_en = 0;
    end else if (!freeze) begin
      m_ent = '{valid: mem_valid, wb_en: WB_EN_in, is_load: MEM_R_EN,
                dest: int'(Dest_in), alu: ALU_Res, mem: Mem_read_value};
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [DW-1:0] snap_res;
    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // REQ-034 style: ALU writeback
    drive(1, 1, 0, 3, 32'h1234_5678, 32'h0, 0, 0);
    tick("alu_wb");
    check("alu_wb.const_res", 64'(Result_WB), 64'h1234_5678);
    check("alu_wb.const_we", 64'(writeBackEn), 64'h1);

    // Load writeback
    drive(1, 1, 1, 7, 32'h100, 32'hDEAD_BEEF, 0, 0);
    tick("load_wb");
    check("load_wb.const_res", 64'(Result_WB), 64'hDEAD_BEEF);

    // PC destination
    drive(1, 1, 0, 15, 32'h0000_0040, 32'h0, 0, 0);
    tick("pc_wb");
    check("pc_wb.const_pcw", 64'(wb_pc_write), 64'h1);
    check("pc_wb.const_we", 64'(writeBackEn), 64'h0);

    // Invalid entry with WB_EN set must not write
    drive(0, 1, 0, 5, 32'hAAAA_5555, 32'h0, 0, 0);
    tick("invalid_wb");

    // Valid entry then 3 frozen cycles with changing inputs
    drive(1, 1, 0, 9, 32'hCAFE_F00D, 32'h1111_2222, 0, 0);
    tick("pre_freeze");
    snap_res = Result_WB;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, i, $urandom, $urandom, 1, 0);
      tick($sformatf("freeze%0d", i));
      check($sformatf("freeze%0d.hold_res", i), 64'(Result_WB), 64'(snap_res));
      check($sformatf("freeze%0d.hold_we", i), 64'(writeBackEn), 64'h1);
    end
    // Flush overrides freeze
    drive(1, 1, 0, 4, 32'h5, 32'h6, 1, 1);
    tick("flush_freeze");
    check("flush_freeze.const_valid", 64'(wb_valid), 64'h0);

    // Asynchronous reset between edges while writing, during freeze
    drive(1, 1, 0, 2, 32'h7777_0000, 32'h0, 0, 0);
    tick("pre_rst");
    drive(1, 1, 0, 6, 32'h1, 32'h2, 1, 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    drive(1, 1, 0, 8, 32'h0BAD_CAFE, 32'h0, 0, 0);
    tick("post_rst");

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      int d;
      d = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) d = 15;
      drive(bit'($urandom_range(0, 4) != 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), d, $urandom, $urandom,
            bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 9) == 0));
      tick($sformatf("rand%0d", n));
    end

`ifdef WB_RETIRE_CNT_EN
    // Five retirements with two frozen cycles interleaved
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    drive(1, 1, 0, 1, 32'h1, 32'h0, 0, 0); tick("cnt_a");
    drive(1, 1, 0, 2, 32'h2, 32'h0, 0, 0); tick("cnt_b");
    drive(1, 1, 0, 3, 32'h3, 32'h0, 0, 0); tick("cnt_c");
    drive(1, 1, 0, 4, 32'h4, 32'h0, 1, 0); tick("cnt_f1");
    drive(1, 1, 0, 4, 32'h4, 32'h0, 1, 0); tick("cnt_f2");
    drive(1, 1, 0, 5, 32'h5, 32'h0, 0, 0); tick("cnt_d");
    drive(1, 1, 0, 6, 32'h6, 32'h0, 0, 0); tick("cnt_e");
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0); tick("cnt_g");
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0); tick("cnt_h");
    check("cnt.const_five", 64'(retire_cnt), 64'd5);

    // Wrap from all-ones
    drive(1, 1, 0, 1, 32'h9, 32'h0, 0, 0); tick("wrap_load");
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tick("wrap");
    check("wrap.const_zero", 64'(retire_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_stage
`default_nettype wire
